ppm_decoder: RTL and testbench
==============================

# ppm_decoder

Receive-side decoder for the pulse-position frames produced by the RC transmitter's `transmit` envelope. It samples the demodulated envelope and locks onto the long sync pulse. It then measures each channel's high time in microseconds and publishes per-channel values once per complete, well-formed frame. It also flags loss of signal.

## Interface
- `FREQ`, 27: clock frequency in MHz; one microsecond equals FREQ cycles.
- `NUM_CH`, 2: channels per frame.
- `SYNC_MIN_US`, 2500: a high time at or above this is a sync pulse.
- `TIMEOUT_US`, 50000: with no input edge for this long, signal is lost.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ppm_in`  in  1  asynchronous envelope; high means carrier on.
- `ch_value`  out  NUM_CH*10  channel k occupies bits [10k+9:10k], range 0..1000.
- `frame_valid`  out  1  one-cycle strobe; `ch_value` updated this cycle.
- `frame_error`  out  1  one-cycle strobe; malformed frame discarded.
- `signal_lost`  out  1  level; high while no valid signal.

## Operation
- Input conditioning:
  - `ppm_in` passes through a two-flop synchronizer, then a registered edge detector.
- Microsecond prescaler:
  - Counts 0..FREQ-1 and emits a tick on wrap.
  - Restarts at 0 on every detected edge.
  - `width_us` counts ticks since the last edge, 16 bits, saturating at 65535.
  - Measured width is therefore floor(cycles/FREQ).
- States:
  - HUNT:
    - On a falling edge with `width_us` ≥ SYNC_MIN_US → GAP, with channel index 0.
    - Otherwise stay in HUNT.
  - GAP (low, between pulses):
    - On a rising edge with `width_us` ≤ 1000 → PULSE.
    - On a rising edge with `width_us` > 1000 → error, HUNT.
  - PULSE (high, channel k):
    - On a falling edge with 400 ≤ `width_us` ≤ 1600:
      - Store clamp(`width_us` − 500, 0, 1000) in the shadow register for channel k.
      - If k = NUM_CH−1, commit → HUNT; otherwise k+1 → GAP.
    - On a falling edge with `width_us` outside that range → error, HUNT.
    - If `width_us` reaches SYNC_MIN_US while still high (sync arrived early) → error, HUNT.
- Commit:
  - Copies all shadow registers to `ch_value` and pulses `frame_valid`.
  - Clears `signal_lost`.
- Error:
  - Pulses `frame_error`.
  - Shadow registers are discarded, so `ch_value` keeps its last committed frame.
- Timeout:
  - A separate counter clears on every edge and counts ticks.
  - At TIMEOUT_US it sets `signal_lost` and forces HUNT.
  - It then saturates.

## Timing
- Reset values:
  - `ch_value` = 500 in every channel.
  - `frame_valid` = 0, `frame_error` = 0, `signal_lost` = 1.
  - State HUNT; all counters 0.
- Latency:
  - Pin edge to internal edge event: 3 cycles (2 synchronizer, 1 detect).
  - Commit is registered: `ch_value` and `frame_valid` change 4 cycles after the pin's last falling edge.
- `frame_valid` and `frame_error` are never high together, and neither is high for more than 1 cycle.
- Edge vs timeout in the same cycle: the edge wins; the timeout counter clears and `signal_lost` is unchanged.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- A frame already in progress when reset is released is ignored until the next sync.

## Configuration
- `PPM_DECODER_FAILSAFE_EN`:
  - Defined: when `signal_lost` rises, `ch_value` is forced to 500 in all channels in the same cycle.
  - Undefined: `ch_value` holds its last committed frame during signal loss.
- Reset values are identical in both builds.

## Structure
- Package `ppm_pkg` holds:
  - the state enum (HUNT, GAP, PULSE);
  - CH_W = 10 and CENTER = 500;
  - MIN_PULSE_US = 400, MAX_PULSE_US = 1600, OFFSET_US = 500, MAX_GAP_US = 1000.
- Sub-module `ppm_input_sync`: two-flop synchronizer plus rise/fall edge strobes, with async active-low reset to 0.

## Test plan
- FREQ=27, NUM_CH=2. Frame: 500 µs low, 500 µs high, 500 µs low, 1500 µs high, 500 µs low, 17000 µs sync high. Repeat twice → first frame ignored (no sync yet); second gives `ch_value` = {1000, 0}, `frame_valid` once, `signal_lost` 0.
- Channel highs of 1000 µs and 1234 µs after sync → values 500 and 734.
- Second channel high of 1700 µs → `frame_error`; `ch_value` keeps its prior values; the next good frame commits.
- `ppm_in` held low for 50 ms → `signal_lost` rises at the 50000 µs tick. With the macro, `ch_value` becomes {500, 500}; without it, values are held.
- Sync arriving after only one channel → `frame_error`; that long pulse is then accepted as sync, and the following frame commits normally.
- Assert `reset_n` during the first channel pulse → reset values at once; no `frame_valid` until a full frame follows a new sync.

Source files
------------

// File: rtl/ppm_pkg.sv
// ppm_pkg: shared types, constants and helpers for the PPM frame decoder.
//   state_e         - frame-tracking FSM states (HUNT, GAP, PULSE)
//   CH_W, CENTER    - channel value width and neutral value
//   *_US            - pulse/gap timing windows in microseconds
//   pulse_to_value  - maps a measured pulse width to a 0..1000 channel value
package ppm_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    GAP   = 2'd1,
    PULSE = 2'd2
  } state_e;

  localparam int CH_W         = 10;
  localparam int CENTER       = 500;
  localparam int MIN_PULSE_US = 400;
  localparam int MAX_PULSE_US = 1600;
  localparam int OFFSET_US    = 500;
  localparam int MAX_GAP_US   = 1000;
  localparam int MAX_VALUE    = 1000;

  // clamp(width - OFFSET_US, 0, MAX_VALUE)
  function automatic logic [CH_W-1:0] pulse_to_value(input logic [15:0] width_us);
    logic [15:0] raw;
    logic [15:0] clamped;
    raw     = (width_us <= 16'(OFFSET_US)) ? 16'd0 : (width_us - 16'(OFFSET_US));
    clamped = (raw > 16'(MAX_VALUE)) ? 16'(MAX_VALUE) : raw;
    return CH_W'(clamped);
  endfunction

endpackage

// File: rtl/ppm_input_sync.sv
// ppm_input_sync: two-flop synchronizer followed by a registered edge detector.
//   clk_i   in   system clock
//   rst_ni  in   asynchronous active-low reset (all flops to 0)
//   ppm_i   in   asynchronous envelope input
//   rise_o  out  one-cycle strobe, 3 cycles after a pin rising edge
//   fall_o  out  one-cycle strobe, 3 cycles after a pin falling edge
module ppm_input_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ppm_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Synchronizer chain, delayed copy and registered edge strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= ppm_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ppm_decoder.sv
// ppm_decoder: locks onto the long sync pulse of a PPM envelope, measures each
// channel's high time in microseconds and publishes a complete frame at once.
//   clock        in   system clock (FREQ MHz)
//   reset_n      in   asynchronous active-low reset
//   ppm_in       in   asynchronous envelope, high = carrier on
//   ch_value     out  NUM_CH x 10-bit channel values, channel k at [10k+9:10k]
//   frame_valid  out  one-cycle strobe, ch_value updated this cycle
//   frame_error  out  one-cycle strobe, malformed frame discarded
//   signal_lost  out  level, high while no valid signal
// Build option: define PPM_DECODER_FAILSAFE_EN to force every channel to the
// centre value when signal loss is detected.
module ppm_decoder
  import ppm_pkg::*;
#(
  parameter int FREQ        = 27,
  parameter int NUM_CH      = 2,
  parameter int SYNC_MIN_US = 2500,
  parameter int TIMEOUT_US  = 50000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     ppm_in,
  output logic [NUM_CH*CH_W-1:0]   ch_value,
  output logic                     frame_valid,
  output logic                     frame_error,
  output logic                     signal_lost
);

  localparam int PW = (FREQ > 1) ? $clog2(FREQ) : 1;
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int KW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] CENTER_V = CH_W'(CENTER);

  logic rise_s;
  logic fall_s;
  logic edge_s;
  logic tick_s;
  logic timeout_s;
  logic pulse_ok_s;
  logic [15:0] width_now_s;
  logic [TW-1:0] tmo_now_s;

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   width_q, width_d;
  logic [TW-1:0] tmo_q, tmo_d;

  state_e state_q, state_d;
  logic [KW-1:0] idx_q, idx_d;
  logic [NUM_CH-1:0][CH_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0][CH_W-1:0] ch_q, ch_d;
  logic valid_q, valid_d;
  logic error_q, error_d;
  logic lost_q, lost_d;

  ppm_input_sync u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .ppm_i  (ppm_in),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  assign edge_s = rise_s | fall_s;
  assign tick_s = (presc_q == PW'(FREQ - 1));

  // Width including a tick landing in this cycle, so the measured value is
  // floor(cycles / FREQ) rather than one short on exact multiples.
  assign width_now_s = (tick_s && (width_q != 16'hFFFF)) ? (width_q + 16'd1) : width_q;
  assign tmo_now_s   = (tick_s && (tmo_q != TW'(TIMEOUT_US))) ? (tmo_q + TW'(1)) : tmo_q;

  // An edge in the same cycle suppresses the timeout.
  assign timeout_s  = !edge_s && tick_s && (tmo_q == TW'(TIMEOUT_US - 1));
  assign pulse_ok_s = (width_now_s >= 16'(MIN_PULSE_US)) && (width_now_s <= 16'(MAX_PULSE_US));

  // Prescaler, pulse-width and timeout counters; all restart on an edge.
  always_comb begin
    presc_d = presc_q;
    width_d = width_q;
    tmo_d   = tmo_q;
    if (edge_s) begin
      presc_d = {PW{1'b0}};
      width_d = 16'd0;
      tmo_d   = {TW{1'b0}};
    end else begin
      presc_d = tick_s ? {PW{1'b0}} : (presc_q + PW'(1));
      width_d = width_now_s;
      tmo_d   = tmo_now_s;
    end
  end

  // Frame FSM: sync lock, gap/pulse qualification, shadow capture and commit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    ch_d     = ch_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    lost_d   = lost_q;
    if (timeout_s) begin
      state_d = HUNT;
      lost_d  = 1'b1;
`ifdef PPM_DECODER_FAILSAFE_EN
      ch_d    = {NUM_CH{CENTER_V}};
`else
      ch_d    = ch_q;
`endif
    end else begin
      case (state_q)
        HUNT: begin
          if (fall_s && (width_now_s >= 16'(SYNC_MIN_US))) begin
            state_d = GAP;
            idx_d   = {KW{1'b0}};
          end else begin
            state_d = HUNT;
          end
        end
        GAP: begin
          if (rise_s) begin
            if (width_now_s <= 16'(MAX_GAP_US)) begin
              state_d = PULSE;
            end else begin
              state_d = HUNT;
              error_d = 1'b1;
            end
          end else begin
            state_d = GAP;
          end
        end
        PULSE: begin
          if (fall_s) begin
            if (pulse_ok_s) begin
              shadow_d[idx_q] = pulse_to_value(width_now_s);
              if (idx_q == KW'(NUM_CH - 1)) begin
                ch_d    = shadow_d;
                valid_d = 1'b1;
                lost_d  = 1'b0;
                state_d = HUNT;
              end else begin
                idx_d   = idx_q + KW'(1);
                state_d = GAP;
              end
            end else begin
              state_d = HUNT;
              error_d = 1'b1;
            end
          end else if (width_now_s >= 16'(SYNC_MIN_US)) begin
            // Sync started before the frame had all its channels.
            state_d = HUNT;
            error_d = 1'b1;
          end else begin
            state_d = PULSE;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= {PW{1'b0}};
      width_q  <= 16'd0;
      tmo_q    <= {TW{1'b0}};
      state_q  <= HUNT;
      idx_q    <= {KW{1'b0}};
      shadow_q <= {NUM_CH{CENTER_V}};
      ch_q     <= {NUM_CH{CENTER_V}};
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      width_q  <= width_d;
      tmo_q    <= tmo_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      lost_q   <= lost_d;
    end
  end

  assign ch_value    = ch_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_ppm_decoder.sv
// Directed bench for ppm_decoder. Runs at FREQ=2 with shortened sync and
// timeout so that full frames fit in a short run; pulse widths are given in
// clock cycles (2 cycles = 1 us).
module tb_ppm_decoder;

  localparam int FREQ    = 2;
  localparam int NUM_CH  = 2;
  localparam int SYNC_US = 1800;
  localparam int TMO_US  = 3000;
  localparam int LOW     = 100;   // 50 us inter-pulse low
  localparam int SYNC    = 3700;  // 1850 us sync high

  logic        clock;
  logic        reset_n;
  logic        ppm_in;
  logic [19:0] ch_value;
  logic        frame_valid;
  logic        frame_error;
  logic        signal_lost;

  int vectors;
  int miscompares;
  int fv_cnt;
  int fe_cnt;
  int strobe_bad;
  int fv0;
  int fe0;
  logic fv_prev;
  logic fe_prev;
  logic [19:0] exp_ch;

  ppm_decoder #(
    .FREQ        (FREQ),
    .NUM_CH      (NUM_CH),
    .SYNC_MIN_US (SYNC_US),
    .TIMEOUT_US  (TMO_US)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ppm_in      (ppm_in),
    .ch_value    (ch_value),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .signal_lost (signal_lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe counters and overlap/width monitor.
  always @(negedge clock) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if ((frame_valid && frame_error) || (frame_valid && fv_prev) || (frame_error && fe_prev))
      strobe_bad <= strobe_bad + 1;
    fv_prev <= frame_valid;
    fe_prev <= frame_error;
  end

  task automatic hold(input logic lvl, input int n);
    ppm_in = lvl;
    repeat (n) @(negedge clock);
  endtask

  // Frame: low, ch0 high, low, ch1 high, low, sync high (widths in cycles).
  task automatic frame(input int a, input int b);
    hold(1'b0, LOW);
    hold(1'b1, a);
    hold(1'b0, LOW);
    hold(1'b1, b);
    hold(1'b0, LOW);
    hold(1'b1, SYNC);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    vectors++;
    if (ch_value !== {10'd500, 10'd500}) begin
      miscompares++;
      $display("FAIL reset_ch: got %h expected %h", ch_value, {10'd500, 10'd500});
    end
    vectors++;
    if ({frame_valid, frame_error, signal_lost} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 001", {frame_valid, frame_error, signal_lost});
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    vectors++;
    if (signal_lost !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_lost: got %b expected 1", signal_lost);
    end
  endtask

  task automatic test_first_frames;
    fv0 = fv_cnt;
    frame(1000, 3000);
    vectors++;
    if (fv_cnt - fv0 !== 0) begin
      miscompares++;
      $display("FAIL unsynced_frame: got %0d valid strobes expected 0", fv_cnt - fv0);
    end
    hold(1'b0, LOW);
    hold(1'b1, 1000);
    hold(1'b0, LOW);
    hold(1'b1, 3000);
    ppm_in = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (frame_valid !== 1'b0 || ch_value !== {10'd500, 10'd500}) begin
      miscompares++;
      $display("FAIL commit_early: got valid=%b ch=%h expected valid=0 ch=%h",
               frame_valid, ch_value, {10'd500, 10'd500});
    end
    @(negedge clock);
    vectors++;
    if (frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_latency: got %b expected 1", frame_valid);
    end
    exp_ch = {10'd1000, 10'd0};
    vectors++;
    if (ch_value !== exp_ch) begin
      miscompares++;
      $display("FAIL frame_500_1500: got %h expected %h", ch_value, exp_ch);
    end
    vectors++;
    if (signal_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_clear: got %b expected 0", signal_lost);
    end
    hold(1'b0, LOW - 4);
    hold(1'b1, SYNC);
    vectors++;
    if (fv_cnt - fv0 !== 1) begin
      miscompares++;
      $display("FAIL valid_count: got %0d expected 1", fv_cnt - fv0);
    end
  endtask

  task automatic test_values;
    fv0 = fv_cnt;
    frame(2000, 2468);
    exp_ch = {10'd734, 10'd500};
    vectors++;
    if (ch_value !== exp_ch || fv_cnt - fv0 !== 1) begin
      miscompares++;
      $display("FAIL frame_1000_1234: got ch=%h n=%0d expected ch=%h n=1", ch_value, fv_cnt - fv0, exp_ch);
    end
  endtask

  task automatic test_bad_pulse;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    frame(2000, 3400);
    vectors++;
    if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
      miscompares++;
      $display("FAIL long_pulse: got err=%0d valid=%0d expected err=1 valid=0", fe_cnt - fe0, fv_cnt - fv0);
    end
    vectors++;
    if (ch_value !== exp_ch) begin
      miscompares++;
      $display("FAIL error_hold: got %h expected %h", ch_value, exp_ch);
    end
    frame(1200, 1400);
    exp_ch = {10'd200, 10'd100};
    vectors++;
    if (ch_value !== exp_ch || fv_cnt - fv0 !== 1) begin
      miscompares++;
      $display("FAIL recover_frame: got ch=%h n=%0d expected ch=%h n=1", ch_value, fv_cnt - fv0, exp_ch);
    end
  endtask

  task automatic test_timeout;
    ppm_in = 1'b0;
    repeat (3 + FREQ * TMO_US) @(negedge clock);
    vectors++;
    if (signal_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got %b expected 0", signal_lost);
    end
    @(negedge clock);
    vectors++;
    if (signal_lost !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_edge: got %b expected 1", signal_lost);
    end
`ifdef PPM_DECODER_FAILSAFE_EN
    exp_ch = {10'd500, 10'd500};
`endif
    vectors++;
    if (ch_value !== exp_ch) begin
      miscompares++;
      $display("FAIL timeout_ch: got %h expected %h", ch_value, exp_ch);
    end
  endtask

  task automatic test_early_sync;
    hold(1'b1, SYNC);
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    hold(1'b0, LOW);
    hold(1'b1, 1000);
    hold(1'b0, LOW);
    hold(1'b1, SYNC);
    vectors++;
    if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0 || ch_value !== exp_ch) begin
      miscompares++;
      $display("FAIL early_sync: got err=%0d valid=%0d ch=%h expected err=1 valid=0 ch=%h",
               fe_cnt - fe0, fv_cnt - fv0, ch_value, exp_ch);
    end
    frame(1100, 2800);
    exp_ch = {10'd900, 10'd50};
    vectors++;
    if (ch_value !== exp_ch || fv_cnt - fv0 !== 1 || signal_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL after_early_sync: got ch=%h n=%0d lost=%b expected ch=%h n=1 lost=0",
               ch_value, fv_cnt - fv0, signal_lost, exp_ch);
    end
  endtask

  task automatic test_reset_mid_frame;
    hold(1'b0, LOW);
    hold(1'b1, 400);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ch_value !== {10'd500, 10'd500} || {frame_valid, frame_error, signal_lost} !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_reset: got ch=%h flags=%b expected ch=%h flags=001",
               ch_value, {frame_valid, frame_error, signal_lost}, {10'd500, 10'd500});
    end
    @(negedge clock);
    reset_n = 1'b1;
    fv0 = fv_cnt;
    hold(1'b1, 600);
    hold(1'b0, LOW);
    hold(1'b1, 3000);
    hold(1'b0, LOW);
    hold(1'b1, SYNC);
    vectors++;
    if (fv_cnt - fv0 !== 0 || ch_value !== {10'd500, 10'd500}) begin
      miscompares++;
      $display("FAIL partial_frame: got n=%0d ch=%h expected n=0 ch=%h", fv_cnt - fv0, ch_value, {10'd500, 10'd500});
    end
    frame(1601, 3200);
    exp_ch = {10'd1000, 10'd300};
    vectors++;
    if (ch_value !== exp_ch || fv_cnt - fv0 !== 1) begin
      miscompares++;
      $display("FAIL post_reset_frame: got ch=%h n=%0d expected ch=%h n=1", ch_value, fv_cnt - fv0, exp_ch);
    end
  endtask

  task automatic test_strobes;
    vectors++;
    if (strobe_bad !== 0) begin
      miscompares++;
      $display("FAIL strobe_shape: got %0d overlapping/long strobes expected 0", strobe_bad);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fv_cnt      = 0;
    fe_cnt      = 0;
    strobe_bad  = 0;
    fv_prev     = 1'b0;
    fe_prev     = 1'b0;
    exp_ch      = {10'd500, 10'd500};
    ppm_in      = 1'b0;
    reset_n     = 1'b1;
    #2 reset_n  = 1'b0;
    test_reset();
    test_first_frames();
    test_values();
    test_bad_pulse();
    test_timeout();
    test_early_sync();
    test_reset_mid_frame();
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
